// File: rtl/traffic_mon_pkg.sv
// Shared types and constants for the traffic-lamp safety monitor.
package traffic_mon_pkg;

  typedef enum logic [1:0] {ST_SYNC, ST_GRN, ST_YLW, ST_RED} lamp_state_e;
  typedef enum logic [2:0] {LC_DARK, LC_GRN, LC_YLW, LC_RED, LC_BAD} lamp_code_e;

  localparam logic [2:0] LAMP_GRN  = 3'b100;
  localparam logic [2:0] LAMP_YLW  = 3'b010;
  localparam logic [2:0] LAMP_RED  = 3'b001;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ILLEGAL  = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_DWELL    = 3'd5;

  typedef struct packed {
    logic illegal;
    logic seq;
    logic short_ylw;
    logic timeout;
    logic rg;
  } dir_flags_t;

  function automatic lamp_code_e lamp_decode(input logic [2:0] gyr);
    case (gyr)
      LAMP_GRN:  return LC_GRN;
      LAMP_YLW:  return LC_YLW;
      LAMP_RED:  return LC_RED;
      LAMP_DARK: return LC_DARK;
      default:   return LC_BAD;
    endcase
  endfunction

  function automatic logic [2:0] dir_fault_code(input dir_flags_t f);
    if (f.illegal)   return FC_ILLEGAL;
    if (f.seq)       return FC_SEQUENCE;
    if (f.short_ylw) return FC_SHORT;
    if (f.timeout)   return FC_DWELL;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/lamp_dir_checker.sv
// One direction's lamp decode, phase FSM and dwell counter.
module lamp_dir_checker
  import traffic_mon_pkg::*;
#(
  parameter int MIN_YLW   = 3,
  parameter int MAX_DWELL = 255,
  parameter int CW        = 8
) (
  input  logic       ck_i,
  input  logic       clr_i,
  input  logic       vld_i,
  input  logic       fm_i,
  input  logic [2:0] gyr_i,
  output dir_flags_t flags_o,
  output logic       go_o
);

  localparam logic [CW-1:0] DW_MAX  = CW'(MAX_DWELL);
  localparam logic [CW-1:0] YLW_MIN = CW'(MIN_YLW - 1);

  lamp_state_e   state_q, state_d, new_st;
  lamp_code_e    code;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          legal_step;

  always_comb begin
    code = lamp_decode(gyr_i);
    case (code)
      LC_GRN:  new_st = ST_GRN;
      LC_YLW:  new_st = ST_YLW;
      LC_RED:  new_st = ST_RED;
      default: new_st = ST_SYNC;
    endcase
    legal_step = (state_q == ST_GRN && new_st == ST_YLW) ||
                 (state_q == ST_YLW && new_st == ST_RED) ||
                 (state_q == ST_RED && new_st == ST_GRN);

    state_d = state_q;
    dwell_d = '0;
    flags_o = '0;
    if (!vld_i) begin
      state_d = ST_SYNC;
    end else if (code == LC_BAD || code == LC_DARK) begin
      // Dark is tolerated while flashing; a bad pattern never is.
      flags_o.illegal = (code == LC_BAD) || !fm_i;
      state_d         = ST_SYNC;
    end else if (fm_i || state_q == ST_SYNC) begin
      state_d = fm_i ? ST_SYNC : new_st;
    end else if (new_st == state_q) begin
      dwell_d         = (dwell_q == DW_MAX) ? dwell_q : dwell_q + 1'b1;
      flags_o.timeout = (state_q != ST_RED) && (dwell_d == DW_MAX);
    end else begin
      state_d           = new_st;
      flags_o.seq       = !legal_step;
      flags_o.short_ylw = (state_q == ST_YLW) && (new_st == ST_RED) && (dwell_q < YLW_MIN);
      flags_o.rg        = (state_q == ST_RED) && (new_st == ST_GRN);
    end
    go_o = vld_i && (code == LC_GRN || code == LC_YLW);
  end

  always_ff @(posedge ck_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= ST_SYNC;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Two-stage lamp safety monitor: sample, check both directions, latch first fault.
module traffic_lamp_monitor
  import traffic_mon_pkg::*;
#(
  parameter int MIN_YLW   = 3,
  parameter int MAX_DWELL = 255,
  parameter int CW        = 8
) (
  input  logic          CK,
  input  logic          CLR,
  input  logic          FM,
  input  logic          GRN1,
  input  logic          YLW1,
  input  logic          RED1,
  input  logic          GRN2,
  input  logic          YLW2,
  input  logic          RED2,
  input  logic          ACK,
  output logic          FAULT,
  output logic [2:0]    FCODE,
  output logic          FDIR,
  output logic [CW-1:0] CYCLES
);

  localparam int NUM_DIRS = 2;

  logic [NUM_DIRS-1:0][2:0] lamps_q;
  logic                     fm_q, vld_q;
  dir_flags_t [NUM_DIRS-1:0] flags;
  logic [NUM_DIRS-1:0]      go;

  logic          fault_q, fault_d, fdir_q, fdir_d, new_dir;
  logic [2:0]    fcode_q, fcode_d, new_code, code1, code2;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          unused_rg2;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
    lamp_dir_checker #(
      .MIN_YLW  (MIN_YLW),
      .MAX_DWELL(MAX_DWELL),
      .CW       (CW)
    ) u_dir (
      .ck_i   (CK),
      .clr_i  (CLR),
      .vld_i  (vld_q),
      .fm_i   (fm_q),
      .gyr_i  (lamps_q[d]),
      .flags_o(flags[d]),
      .go_o   (go[d])
    );
  end

  assign unused_rg2 = flags[1].rg;

  always_comb begin
    code1    = dir_fault_code(flags[0]);
    code2    = dir_fault_code(flags[1]);
    new_code = FC_NONE;
    new_dir  = 1'b0;
    if (&go) begin
      new_code = FC_CONFLICT;
    end else if (code1 != FC_NONE && (code2 == FC_NONE || code1 <= code2)) begin
      new_code = code1;
    end else if (code2 != FC_NONE) begin
      new_code = code2;
      new_dir  = 1'b1;
    end

    fault_d = fault_q;
    fcode_d = fcode_q;
    fdir_d  = fdir_q;
    // An acknowledge opens the latch, so a fault in the same cycle is captured.
    if (new_code != FC_NONE && (!fault_q || ACK)) begin
      fault_d = 1'b1;
      fcode_d = new_code;
      fdir_d  = new_dir;
    end else if (ACK) begin
      fault_d = 1'b0;
      fcode_d = FC_NONE;
      fdir_d  = 1'b0;
    end
    cycles_d = cycles_q + CW'(flags[0].rg);
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      lamps_q  <= '0;
      fm_q     <= 1'b0;
      vld_q    <= 1'b0;
      fault_q  <= 1'b0;
      fcode_q  <= FC_NONE;
      fdir_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      lamps_q  <= {{GRN2, YLW2, RED2}, {GRN1, YLW1, RED1}};
      fm_q     <= FM;
      vld_q    <= 1'b1;
      fault_q  <= fault_d;
      fcode_q  <= fcode_d;
      fdir_q   <= fdir_d;
      cycles_q <= cycles_d;
    end
  end

  assign FAULT  = fault_q;
  assign FCODE  = fcode_q;
  assign FDIR   = fdir_q;
  assign CYCLES = cycles_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Scoreboard bench: directed lamp sequences queue expected fault state per cycle.
module tb_traffic_lamp_monitor;

  localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, D = 3'b000;

  logic       CK, CLR, FM, ACK;
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic       FAULT, FDIR;
  logic [2:0] FCODE;
  logic [7:0] CYCLES;
  logic [2:0] l1, l2;

  assign {GRN1, YLW1, RED1} = l1;
  assign {GRN2, YLW2, RED2} = l2;

  traffic_lamp_monitor #(.MIN_YLW(3), .MAX_DWELL(255), .CW(8)) dut (
    .CK(CK), .CLR(CLR), .FM(FM),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .ACK(ACK), .FAULT(FAULT), .FCODE(FCODE), .FDIR(FDIR), .CYCLES(CYCLES)
  );

  typedef struct {
    int         at;
    logic       f;
    logic [2:0] c;
    logic       d;
    bit         chkc;
    logic [7:0] cy;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  exp_t  e;
  string nm;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  initial CK = 1'b0;
  always #5 CK = ~CK;
  always @(posedge CK) cyc++;

  always @(negedge CK) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      e  = q.pop_front();
      nm = nq.pop_front();
      n_cmp++;
      if (e.at != cyc || FAULT !== e.f || FCODE !== e.c || FDIR !== e.d ||
          (e.chkc && CYCLES !== e.cy)) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got fault=%0b code=%0d dir=%0b cycles=%0d, expected fault=%0b code=%0d dir=%0b cycles=%0d%s",
                 nm, cyc, e.at, FAULT, FCODE, FDIR, CYCLES, e.f, e.c, e.d, e.cy,
                 e.chkc ? "" : " (cycles not checked)");
      end
    end
  end

  task automatic push(input int at, input logic f, input logic [2:0] c, input logic d,
                      input bit chkc, input logic [7:0] cy, input string name);
    exp_t x;
    x.at = at; x.f = f; x.c = c; x.d = d; x.chkc = chkc; x.cy = cy;
    q.push_back(x);
    nq.push_back(name);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Apply a lamp pair for n cycles; optionally expect no fault two edges later.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      l1 = a;
      l2 = b;
      if (chk) push(cyc + 2, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "no_fault");
      tick();
      ACK = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
      q.delete();
      nq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n, m;

  initial begin
    CLR = 1'b1; FM = 1'b0; ACK = 1'b0; l1 = G; l2 = R;
    tick(); tick();
    push(cyc, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0, "reset");
    tick();
    CLR = 1'b0;

    // Two full laps, no faults; second dir1 green is the first counted R->G.
    for (int lap = 0; lap < 2; lap++) begin
      step(G, R, 10, 1); step(Y, R, 3, 1);
      step(R, G, 10, 1); step(R, Y, 3, 1); step(R, R, 1, 1);
    end
    push(cyc + 1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd1, "cycles_after_laps");

    // Conflict, held until acknowledged.
    step(G, R, 3, 1);
    n = cyc; step(G, G, 1, 0);
    push(n + 2, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, "conflict");
    step(G, R, 6, 0);
    push(cyc, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, "conflict_held");
    ACK = 1'b1; m = cyc; step(G, R, 1, 0);
    push(m + 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "ack_conflict");

    // Skipped yellow on dir2.
    step(Y, R, 3, 1); step(R, R, 1, 1); step(R, G, 3, 1);
    n = cyc; step(R, R, 1, 0);
    push(n + 2, 1'b1, 3'd3, 1'b1, 1'b0, 8'd0, "skip_ylw_dir2");
    step(R, R, 4, 0);
    ACK = 1'b1; m = cyc; step(R, R, 1, 0);
    push(m + 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "ack_skip");

    // Yellow and red together on dir2.
    n = cyc; step(R, 3'b011, 1, 0);
    push(n + 2, 1'b1, 3'd2, 1'b1, 1'b0, 8'd0, "bad_pattern_dir2");
    step(R, R, 4, 0);
    ACK = 1'b1; m = cyc; step(R, R, 1, 0);
    push(m + 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "ack_bad");

    // Yellow for 2 samples is short; 3 samples is fine.
    step(G, R, 2, 1); step(Y, R, 2, 1);
    n = cyc; step(R, R, 1, 0);
    push(n + 2, 1'b1, 3'd4, 1'b0, 1'b0, 8'd0, "short_ylw");
    step(R, R, 3, 0);
    ACK = 1'b1; m = cyc; step(R, R, 1, 0);
    push(m + 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "ack_short");
    step(G, R, 2, 1); step(Y, R, 3, 1); step(R, R, 3, 1);

    // Green timeout on the 256th sample; red never times out.
    step(G, R, 255, 1);
    n = cyc; step(G, R, 1, 0);
    push(n + 2, 1'b1, 3'd5, 1'b0, 1'b0, 8'd0, "grn_timeout");
    step(Y, R, 3, 0); step(R, R, 3, 0);
    ACK = 1'b1; m = cyc; step(R, R, 1, 0);
    push(m + 1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0, "ack_timeout");
    step(R, R, 1000, 1);

    // Flash mode: dark is legal, simultaneous yellows conflict.
    FM = 1'b1;
    step(D, D, 4, 1);
    n = cyc; step(Y, Y, 1, 0);
    push(n + 2, 1'b1, 3'd1, 1'b0, 1'b0, 8'd0, "fm_conflict");
    step(D, D, 1, 0); step(Y, Y, 1, 0); step(D, D, 1, 0);
    n = cyc; step(D, 3'b110, 1, 0);
    ACK = 1'b1; m = cyc; step(D, D, 1, 0);
    push(m + 1, 1'b1, 3'd2, 1'b1, 1'b0, 8'd0, "ack_vs_new_fault");
    step(D, D, 2, 0);
    push(cyc, 1'b1, 3'd2, 1'b1, 1'b0, 8'd0, "fault_held");
    drain();

    // Asynchronous clear mid-fault, then a clean restart.
    CLR = 1'b1;
    push(cyc, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0, "clr_async");
    FM = 1'b0; l1 = R; l2 = R;
    tick();
    CLR = 1'b0;
    step(R, R, 3, 1);
    push(cyc + 1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0, "post_clr");

    // CYCLES wraps after 256 dir1 R->G transitions.
    for (int i = 1; i <= 256; i++) begin
      step(G, R, 1, 1);
      if (i == 1)   push(cyc + 1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd1, "cycles_1");
      if (i == 255) push(cyc + 1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd255, "cycles_255");
      if (i == 256) push(cyc + 1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0, "cycles_wrap");
      step(Y, R, 3, 1);
      step(R, R, 1, 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
